// File: rtl/duc_pkg.sv
// Shared widths, nominal symbol levels, the {Q, I} input pair and the
// output saturation helper for the duc up-converter.
package duc_pkg;

    localparam int FRAME_LEN_DEF = 680;
    localparam int IN_W          = 8;
    localparam int CAR_W         = 16;
    localparam int OUT_W         = 16;
    localparam int PROD_W        = IN_W + CAR_W;
    localparam int DIFF_W        = PROD_W + 1;

    localparam logic signed [IN_W-1:0] LVL_P1 = 8'sd1;
    localparam logic signed [IN_W-1:0] LVL_P3 = 8'sd3;
    localparam logic signed [IN_W-1:0] LVL_P5 = 8'sd5;
    localparam logic signed [IN_W-1:0] LVL_P7 = 8'sd7;
    localparam logic signed [IN_W-1:0] LVL_N1 = -8'sd1;
    localparam logic signed [IN_W-1:0] LVL_N3 = -8'sd3;
    localparam logic signed [IN_W-1:0] LVL_N5 = -8'sd5;
    localparam logic signed [IN_W-1:0] LVL_N7 = -8'sd7;

    typedef struct packed {
        logic [IN_W-1:0] q;
        logic [IN_W-1:0] i;
    } iq_t;

    // Returns {clipped, value} with value clamped to the OUT_W signed range.
    function automatic logic [OUT_W:0] saturate(input logic signed [DIFF_W-1:0] v);
        logic signed [DIFF_W-1:0] max_v;
        logic signed [DIFF_W-1:0] min_v;
        max_v = DIFF_W'(2**(OUT_W-1) - 1);
        min_v = -max_v - 1;
        if (v > max_v)
            return {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
        else if (v < min_v)
            return {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
        else
            return {1'b0, v[OUT_W-1:0]};
    endfunction

endpackage

// File: rtl/duc_carrier_ram.sv
// Carrier table for duc: simple dual-port {sin, cos} RAM with one write
// port and a registered, enable-gated read port.
module duc_carrier_ram #(
    parameter int DEPTH  = 680,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/duc.sv
// Transmit digital up-converter: out = I*cos[k] - Q*sin[k] through a 4-stage
// stallable pipeline. Define DUC_ROUND_EN for round-half-up instead of floor.
module duc
    import duc_pkg::*;
#(
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int ADDR_W    = 10,
    parameter int OUT_SHIFT = 4
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              car_wr_en,
    input  logic [ADDR_W-1:0] car_wr_addr,
    input  logic [CAR_W-1:0]  car_wr_cos,
    input  logic [CAR_W-1:0]  car_wr_sin,
    output logic              car_ready,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [15:0]       s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [OUT_W-1:0]  m_axis_tdata,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser
);

    localparam logic [ADDR_W:0]   FRAME_LEN_W = (ADDR_W+1)'(FRAME_LEN);
    localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(FRAME_LEN - 1);

`ifdef DUC_ROUND_EN
    localparam logic signed [DIFF_W-1:0] ROUND_ADD = DIFF_W'(2**(OUT_SHIFT-1));
`else
    localparam logic signed [DIFF_W-1:0] ROUND_ADD = '0;
`endif

    logic                     pipe_en;
    logic                     accept;
    logic                     wr_ok;
    logic [ADDR_W-1:0]        k_reg;
    logic [2*CAR_W-1:0]       car_rd;

    logic                     s1_valid_reg;
    logic                     s1_last_reg;
    iq_t                      s1_iq_reg;

    logic                     s2_valid_reg;
    logic                     s2_last_reg;
    logic signed [PROD_W-1:0] p_cos_reg;
    logic signed [PROD_W-1:0] p_sin_reg;
    logic signed [PROD_W-1:0] p_cos_next;
    logic signed [PROD_W-1:0] p_sin_next;

    logic                     s3_valid_reg;
    logic                     s3_last_reg;
    logic signed [DIFF_W-1:0] diff_reg;
    logic signed [DIFF_W-1:0] diff_next;

    logic signed [DIFF_W-1:0] shifted;
    logic [OUT_W:0]           sat_res;

    assign pipe_en       = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = car_ready && pipe_en;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign wr_ok         = car_wr_en && !car_ready && ({1'b0, car_wr_addr} < FRAME_LEN_W);

    duc_carrier_ram #(
        .DEPTH  (FRAME_LEN),
        .ADDR_W (ADDR_W),
        .DATA_W (2*CAR_W)
    ) u_ram (
        .clk     (aclk),
        .wr_en   (wr_ok),
        .wr_addr (car_wr_addr),
        .wr_data ({car_wr_sin, car_wr_cos}),
        .rd_en   (pipe_en),
        .rd_addr (k_reg),
        .rd_data (car_rd)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            car_ready <= 1'b0;
        end else if (wr_ok && car_wr_addr == LAST_IDX) begin
            car_ready <= 1'b1;
        end
    end

    // Frame index restarts after tlast or after the final table entry.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            k_reg <= '0;
        end else if (accept) begin
            if (s_axis_tlast || k_reg == LAST_IDX)
                k_reg <= '0;
            else
                k_reg <= k_reg + 1'b1;
        end
    end

    always_comb begin
        p_cos_next = PROD_W'($signed(s1_iq_reg.i)) * PROD_W'($signed(car_rd[CAR_W-1:0]));
        p_sin_next = PROD_W'($signed(s1_iq_reg.q)) * PROD_W'($signed(car_rd[2*CAR_W-1:CAR_W]));
        diff_next  = DIFF_W'(p_cos_reg) - DIFF_W'(p_sin_reg) + ROUND_ADD;
        shifted    = diff_reg >>> OUT_SHIFT;
        sat_res    = saturate(shifted);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_valid_reg  <= 1'b0;
            s1_last_reg   <= 1'b0;
            s1_iq_reg     <= '0;
            s2_valid_reg  <= 1'b0;
            s2_last_reg   <= 1'b0;
            p_cos_reg     <= '0;
            p_sin_reg     <= '0;
            s3_valid_reg  <= 1'b0;
            s3_last_reg   <= 1'b0;
            diff_reg      <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= 1'b0;
        end else if (pipe_en) begin
            s1_valid_reg  <= accept;
            s1_last_reg   <= s_axis_tlast;
            s1_iq_reg     <= iq_t'(s_axis_tdata);
            s2_valid_reg  <= s1_valid_reg;
            s2_last_reg   <= s1_last_reg;
            p_cos_reg     <= p_cos_next;
            p_sin_reg     <= p_sin_next;
            s3_valid_reg  <= s2_valid_reg;
            s3_last_reg   <= s2_last_reg;
            diff_reg      <= diff_next;
            m_axis_tvalid <= s3_valid_reg;
            m_axis_tdata  <= sat_res[OUT_W-1:0];
            m_axis_tlast  <= s3_last_reg;
            m_axis_tuser  <= sat_res[OUT_W];
        end
    end

endmodule

// File: tb/tb_duc.sv
// Directed self-checking bench for duc: table loads, mixing, saturation,
// framing, backpressure, rounding and asynchronous reset.
module tb_duc;
    import duc_pkg::*;

    localparam int FL = 680;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic        car_wr_en = 1'b0;
    logic [9:0]  car_wr_addr = '0;
    logic [15:0] car_wr_cos = '0;
    logic [15:0] car_wr_sin = '0;
    logic        car_ready;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [15:0] s_axis_tdata = '0;
    logic        s_axis_tlast = 1'b0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tuser;

    duc #(.FRAME_LEN(FL), .ADDR_W(10), .OUT_SHIFT(4)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .car_wr_en     (car_wr_en),
        .car_wr_addr   (car_wr_addr),
        .car_wr_cos    (car_wr_cos),
        .car_wr_sin    (car_wr_sin),
        .car_ready     (car_ready),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor: records handshakes and checks that stalled beats hold.
    int          got_d[$];
    bit          got_l[$];
    bit          got_u[$];
    int          out_cyc[$];
    int          acc_cyc[$];
    int          block_cnt = 0;
    bit          hold_pend = 1'b0;
    logic [18:0] held;

    always @(negedge aclk) begin
        if (!aresetn) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend)
                check("hold", {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata}, held);
            if (s_axis_tvalid && s_axis_tready)
                acc_cyc.push_back(cyc);
            if (car_ready && !s_axis_tready)
                block_cnt++;
            if (m_axis_tvalid && m_axis_tready) begin
                got_d.push_back(int'($signed(m_axis_tdata)));
                got_l.push_back(m_axis_tlast);
                got_u.push_back(m_axis_tuser);
                out_cyc.push_back(cyc);
            end
            hold_pend = m_axis_tvalid && !m_axis_tready;
            held      = {m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata};
        end
    end

    int exp_d[$];
    bit exp_l[$];
    bit exp_u[$];
    int gp = 0;
    int ap = 0;

    task automatic exp_beat(input int d, input bit l, input bit u);
        exp_d.push_back(d);
        exp_l.push_back(l);
        exp_u.push_back(u);
    endtask

    task automatic reset_dut();
        s_axis_tvalid = 1'b0;
        car_wr_en     = 1'b0;
        m_axis_tready = 1'b1;
        aresetn       = 1'b0;
        repeat (2) @(posedge aclk);
        #1 aresetn = 1'b1;
        gp = got_d.size();
        ap = acc_cyc.size();
    endtask

    task automatic load_table(input bit ramp, input int cv, input int sv);
        for (int a = 0; a < FL; a++) begin
            if (a == FL - 1) begin
                car_wr_en   = 1'b1;
                car_wr_addr = 10'd700;
                car_wr_cos  = 16'h1234;
                car_wr_sin  = 16'h1234;
                @(posedge aclk); #1;
                check("ready_early", car_ready, 0);
            end
            car_wr_en   = 1'b1;
            car_wr_addr = 10'(a);
            car_wr_cos  = ramp ? 16'(16 * a) : 16'(cv);
            car_wr_sin  = 16'(sv);
            @(posedge aclk); #1;
        end
        car_wr_en = 1'b0;
        check("car_ready", car_ready, 1);
    endtask

    task automatic send(input logic [7:0] i, input logic [7:0] q, input bit last);
        int t;
        t = 0;
        s_axis_tdata  = {q, i};
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        while (!s_axis_tready) begin
            t++;
            if (t > 200) begin
                check("send_timeout", 0, 1);
                s_axis_tvalid = 1'b0;
                return;
            end
            @(negedge aclk);
        end
        @(posedge aclk); #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic compare_outs(input string tag);
        int n;
        int t;
        n = exp_d.size();
        t = 0;
        while (got_d.size() < gp + n && t < 300) begin
            @(posedge aclk); #1;
            t++;
        end
        if (got_d.size() < gp + n)
            check({tag, "_count"}, got_d.size() - gp, n);
        for (int j = 0; j < n; j++) begin
            if (gp + j < got_d.size()) begin
                check({tag, "_data"}, got_d[gp+j], exp_d[j]);
                check({tag, "_last"}, got_l[gp+j], exp_l[j]);
                check({tag, "_user"}, got_u[gp+j], exp_u[j]);
            end
        end
        gp += n;
        exp_d.delete();
        exp_l.delete();
        exp_u.delete();
    endtask

    initial begin
        int g0;
        int a0;
        int b0;
        bit pre_valid;

        // Reset state
        #1 aresetn = 1'b0;
        #2;
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_tdata", m_axis_tdata, 0);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_car_ready", car_ready, 0);
        reset_dut();

        // cos=16384: 7*16384 >>> 4 = 7168; write after load must be ignored
        load_table(0, 16384, 0);
        car_wr_en = 1'b1; car_wr_addr = 10'd0; car_wr_cos = 16'd0;
        @(posedge aclk); #1;
        car_wr_en = 1'b0;
        g0 = gp; a0 = ap;
        for (int b = 0; b < 5; b++) begin
            send(8'd7, 8'd0, 1'b0);
            exp_beat(7168, 0, 0);
        end
        compare_outs("cos_only");
        if (g0 < out_cyc.size() && a0 < acc_cyc.size())
            check("latency", out_cyc[g0] - acc_cyc[a0], 4);
        else
            check("latency_missing", 0, 1);

        // sin=16384, Q=3: -(3*16384) >>> 4 = -3072
        reset_dut();
        load_table(0, 0, 16384);
        for (int b = 0; b < 3; b++) begin
            send(8'd0, 8'd3, 1'b0);
            exp_beat(-3072, 0, 0);
        end
        compare_outs("sin_only");

        // Saturation at both rails, plus an in-range beat carrying tlast
        reset_dut();
        load_table(0, 32767, -32767);
        send(8'd127, 8'd127, 1'b0);
        exp_beat(32767, 0, 1);
        send(8'h80, 8'h80, 1'b0);
        exp_beat(-32768, 0, 1);
        send(8'd0, 8'hFF, 1'b1);
        exp_beat(-2048, 1, 0);
        compare_outs("sat");

        // Ramp table cos[k]=16k, I=1 -> output k; tlast on beat 9 restarts
        reset_dut();
        load_table(1, 0, 0);
        for (int b = 0; b < 10; b++) begin
            send(8'd1, 8'd0, b == 9);
            exp_beat(b, b == 9, 0);
        end
        send(8'd1, 8'd0, 1'b1);
        exp_beat(0, 1, 0);
        compare_outs("tlast_wrap");

        // 681 beats without tlast: index wraps after FRAME_LEN-1
        for (int b = 0; b < FL + 1; b++) begin
            send(8'd1, 8'd0, 1'b0);
            exp_beat(b % FL, 0, 0);
        end
        compare_outs("frame_wrap");

        // Backpressure: stream 20 beats while downstream stalls 10 cycles
        send(8'd1, 8'd0, 1'b1);
        exp_beat(1, 1, 0);
        compare_outs("resync");
        b0 = block_cnt;
        fork
            begin
                for (int b = 0; b < 20; b++) begin
                    send(8'd1, 8'd0, (b % 10) == 9);
                    exp_beat(b % 10, (b % 10) == 9, 0);
                end
            end
            begin
                repeat (6) @(posedge aclk);
                #1 m_axis_tready = 1'b0;
                repeat (10) @(posedge aclk);
                #1 m_axis_tready = 1'b1;
            end
        join
        compare_outs("stall");
        check("stall_block", block_cnt > b0, 1);

        // Rounding on the shift: +0.5 and -0.5 LSB cases
        reset_dut();
        load_table(0, 8, 0);
        send(8'd1, 8'd0, 1'b0);
`ifdef DUC_ROUND_EN
        exp_beat(1, 0, 0);
`else
        exp_beat(0, 0, 0);
`endif
        compare_outs("round_pos");
        reset_dut();
        load_table(0, -8, 0);
        send(8'd1, 8'd0, 1'b0);
`ifdef DUC_ROUND_EN
        exp_beat(0, 0, 0);
`else
        exp_beat(-1, 0, 0);
`endif
        compare_outs("round_neg");

        // Asynchronous reset mid-frame with output valid
        reset_dut();
        load_table(1, 0, 0);
        for (int b = 0; b < 5; b++)
            send(8'd1, 8'd0, 1'b0);
        #1 pre_valid = m_axis_tvalid;
        check("pre_rst_valid", pre_valid, 1);
        aresetn = 1'b0;
        #1;
        check("arst_m_tvalid", m_axis_tvalid, 0);
        check("arst_car_ready", car_ready, 0);
        check("arst_s_tready", s_axis_tready, 0);
        check("arst_m_tdata", m_axis_tdata, 0);
        reset_dut();
        load_table(1, 0, 0);
        send(8'd1, 8'd0, 1'b0);
        exp_beat(0, 0, 0);
        compare_outs("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
